// File: rtl/data_bus_arbiter_pkg.sv
// Shared definitions for the MiniRISC data-bus arbiter: FSM state codes and width helpers.
package data_bus_arbiter_pkg;

    localparam logic [1:0] ARB_IDLE       = 2'd0;
    localparam logic [1:0] ARB_GRANT      = 2'd1;
    localparam logic [1:0] ARB_TURNAROUND = 2'd2;

    // Index width for an N-entry one-hot vector, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Width of a counter that must hold 0..max without wrapping.
    function automatic int cnt_width(input int max);
        return (max <= 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/data_bus_arbiter_picker.sv
// Round-robin priority picker: first requester after 'last', wrapping modulo NUM_MASTERS.
module rr_priority_picker
    import data_bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int IDX_W       = 2
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       last,
    output logic [IDX_W-1:0]       pick,
    output logic                   valid
);

    logic [IDX_W-1:0] idx;

    // Searching last+1 .. last+N puts the previous owner at lowest priority.
    always_comb begin
        pick  = '0;
        valid = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            idx = IDX_W'((int'(last) + k) % NUM_MASTERS);
            if (!valid && req[idx]) begin
                valid = 1'b1;
                pick  = idx;
            end
        end
    end

endmodule

// File: rtl/data_bus_arbiter.sv
// MiniRISC data-memory bus arbiter: round-robin grant, 1-cycle turnaround, hold watchdog.
module data_bus_arbiter
    import data_bus_arbiter_pkg::*;
#(
    parameter  int NUM_MASTERS = 4,
    parameter  int MAX_HOLD    = 255,
    localparam int IDX_W       = idx_width(NUM_MASTERS),
    localparam int HC_W        = cnt_width(MAX_HOLD)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] req,
    output logic [NUM_MASTERS-1:0] grant,
    output logic [IDX_W-1:0]       owner,
    output logic                   bus_busy,
    output logic                   hold_timeout,
    input  logic                   timeout_clr,
    output logic [1:0]             arb_state
);

    // Handshake: req[i] is a level held until the master is done; grant[i] stays
    // high while req[i] stays high, and one idle bus cycle separates two owners.

    logic [1:0]             state, state_d;
    logic [NUM_MASTERS-1:0] grant_d;
    logic [IDX_W-1:0]       owner_d;
    logic [IDX_W-1:0]       last, last_d;
    logic [HC_W-1:0]        hold_cnt, hold_cnt_d;
    logic                   timeout_set;
    logic [IDX_W-1:0]       pick;
    logic                   pick_valid;

    rr_priority_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_picker (
        .req   (req),
        .last  (last),
        .pick  (pick),
        .valid (pick_valid)
    );

    always_comb begin
        state_d     = state;
        grant_d     = grant;
        owner_d     = owner;
        last_d      = last;
        hold_cnt_d  = hold_cnt;
        timeout_set = 1'b0;
        case (state)
            ARB_IDLE, ARB_TURNAROUND: begin
                grant_d = '0;
                if (pick_valid) begin
                    state_d       = ARB_GRANT;
                    grant_d[pick] = 1'b1;
                    owner_d       = pick;
                    last_d        = pick;
                    hold_cnt_d    = '0;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_GRANT: begin
                if (req[owner]) begin
                    if (int'(hold_cnt) < MAX_HOLD) hold_cnt_d = hold_cnt + 1'b1;
                    // Flag as the counter reaches MAX_HOLD; the grant itself is kept.
                    if (MAX_HOLD > 0 && int'(hold_cnt) + 1 >= MAX_HOLD) timeout_set = 1'b1;
                end else begin
                    state_d = ARB_TURNAROUND;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ARB_IDLE;
            grant        <= '0;
            owner        <= '0;
            last         <= IDX_W'(NUM_MASTERS - 1);
            hold_cnt     <= '0;
            hold_timeout <= 1'b0;
        end else begin
            state    <= state_d;
            grant    <= grant_d;
            owner    <= owner_d;
            last     <= last_d;
            hold_cnt <= hold_cnt_d;
            if (timeout_set)      hold_timeout <= 1'b1;
            else if (timeout_clr) hold_timeout <= 1'b0;
        end
    end

    assign bus_busy  = (state != ARB_IDLE);
    assign arb_state = state;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Scoreboard bench for data_bus_arbiter: random and directed req patterns vs a behavioural model.
module tb_data_bus_arbiter;
    import data_bus_arbiter_pkg::*;

    localparam int N    = 4;
    localparam int MAXH = 8;
    localparam int W    = N + 2 + 1 + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic         timeout_clr = 1'b0;
    logic [N-1:0] grant;
    logic [1:0]   owner;
    logic         bus_busy;
    logic         hold_timeout;
    logic [1:0]   arb_state;

    data_bus_arbiter #(
        .NUM_MASTERS (N),
        .MAX_HOLD    (MAXH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .grant        (grant),
        .owner        (owner),
        .bus_busy     (bus_busy),
        .hold_timeout (hold_timeout),
        .timeout_clr  (timeout_clr),
        .arb_state    (arb_state)
    );

    always #5 clk = ~clk;

    logic [W-1:0] exp_q[$];
    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model: who holds the bus, whether a gap cycle is running, round-robin pointer.
    int m_holder = -1;
    int m_owner  = 0;
    int m_last   = N - 1;
    int m_held   = 0;
    bit m_gap    = 1'b0;
    bit m_to     = 1'b0;

    function automatic void model_reset();
        m_holder = -1;
        m_owner  = 0;
        m_last   = N - 1;
        m_held   = 0;
        m_gap    = 1'b0;
        m_to     = 1'b0;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] r);
        for (int k = 1; k <= N; k++) begin
            if (r[(m_last + k) % N]) return (m_last + k) % N;
        end
        return -1;
    endfunction

    function automatic void model_advance(input logic [N-1:0] r, input logic c);
        bit set = 1'b0;
        int p;
        if (m_holder >= 0) begin
            if (r[m_holder]) begin
                if (m_held < MAXH) m_held++;
                if (MAXH > 0 && m_held >= MAXH) set = 1'b1;
            end else begin
                m_holder = -1;
                m_gap    = 1'b1;
            end
        end else begin
            p     = rr_pick(r);
            m_gap = 1'b0;
            if (p >= 0) begin
                m_holder = p;
                m_owner  = p;
                m_last   = p;
                m_held   = 0;
            end
        end
        if (set)    m_to = 1'b1;
        else if (c) m_to = 1'b0;
    endfunction

    function automatic logic [W-1:0] model_out();
        logic [N-1:0] g = '0;
        logic [1:0]   o = 2'(m_owner);
        logic         b = (m_holder >= 0) || m_gap;
        if (m_holder >= 0) g[m_holder] = 1'b1;
        return {g, o, b, m_to};
    endfunction

    function automatic void check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b (grant,owner,busy,timeout) at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: every falling edge compares the DUT against the oldest pending expectation.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("scoreboard", {grant, owner, bus_busy, hold_timeout}, e);
            check("onehot", W'(($countones(grant) <= 1) && (grant == '0 || grant[owner] === 1'b1)), W'(1));
        end
    end

    task automatic step(input logic [N-1:0] r, input logic c);
        @(negedge clk);
        #1;
        rst         = 1'b1;
        req         = r;
        timeout_clr = c;
        model_advance(r, c);
        exp_q.push_back(model_out());
    endtask

    // Reset asserted between edges; outputs must clear without waiting for a clock.
    task automatic do_reset(input logic [N-1:0] r);
        @(negedge clk);
        #1;
        req         = r;
        timeout_clr = 1'b0;
        rst         = 1'b0;
        #1;
        model_reset();
        check("async_reset", {grant, owner, bus_busy, hold_timeout}, model_out());
        check("reset_state", W'(arb_state), W'(ARB_IDLE));
        exp_q.push_back(model_out());
    endtask

    task automatic rr_run(input int cycles, input int hold);
        logic [N-1:0] r;
        for (int i = 0; i < cycles; i++) begin
            r = '1;
            if (m_holder >= 0 && m_held >= hold - 1) r[m_holder] = 1'b0;
            step(r, 1'b0);
        end
    endtask

    initial begin
        logic [N-1:0] rr;
        // Reset with all masters requesting, then master 0 first.
        do_reset(4'b1111);
        step(4'b1111, 1'b0);
        // Round-robin with 3-cycle tenures.
        rr_run(22, 3);
        // Single master pulse from idle.
        do_reset(4'b0000);
        repeat (2) step(4'b0000, 1'b0);
        repeat (5) step(4'b0100, 1'b0);
        repeat (4) step(4'b0000, 1'b0);
        // Watchdog: master 1 holds 20 cycles, clear collides with set, then clear when idle.
        do_reset(4'b0000);
        step(4'b0000, 1'b0);
        for (int i = 0; i < 20; i++) step(4'b0010, i == 14);
        repeat (3) step(4'b0000, 1'b0);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b0);
        // Withdrawn request while master 0 owns the bus.
        repeat (3) step(4'b0001, 1'b0);
        step(4'b1001, 1'b0);
        repeat (2) step(4'b0001, 1'b0);
        repeat (4) step(4'b0000, 1'b0);
        // Async reset mid-grant, master 0 wins on release.
        repeat (3) step(4'b0100, 1'b0);
        do_reset(4'b1111);
        repeat (3) step(4'b1111, 1'b0);
        // Random traffic with occasional clears and mid-grant resets.
        rr = '0;
        for (int i = 0; i < 400; i++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 5) == 0) rr[b] = ~rr[b];
            end
            if (m_holder >= 0 && $urandom_range(0, 60) == 0) do_reset(rr);
            else step(rr, $urandom_range(0, 19) == 0);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
